landing_request_queue: RTL and testbench

- Upstream feeder for the runway picker: buffers incoming landing requests (approach direction plus emergency flag) and issues them one at a time as a one-cycle `en` pulse with a stable `d`.
- A request is dispatched only when at least one runway reports free.
- A minimum spacing is enforced between dispatches.
- A single emergency slot bypasses the normal FIFO.

---
 rtl/landing_request_queue.sv | 171 +++++++++++++++++
 tb/tb_landing_request_queue.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/landing_request_queue.sv
// Landing request queue: buffers normal requests in a FIFO plus one emergency
// slot, and issues them to the runway picker as spaced one-cycle dispatches.
//
//  state | meaning
//  IDLE  | waiting for a pending request and a free runway
//  ISSUE | en high for one cycle; spacing timer loaded on exit
//  HOLD  | spacing timer counting down; decides again at terminal count
module landing_request_queue #(
   parameter int DEPTH   = 4,
   parameter int AW      = 2,
   parameter int SPACING = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   input  logic [1:0]    req_dir,
   input  logic          req_emerg,
   output logic          req_ready,
   input  logic          runway_a_busy,
   input  logic          runway_b_busy,
   output logic          en,
   output logic [1:0]    d,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty,
   output logic          emerg_pending,
   output logic          dropped
);

   localparam int              CW      = (SPACING > 1) ? $clog2(SPACING) : 1;
   localparam logic [CW-1:0]   SP_LOAD = CW'(SPACING - 1);
   localparam logic [AW:0]     CNT_MAX = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   spc_cnt_q, spc_cnt_d;

   logic [1:0]      fifo_mem [DEPTH];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [AW:0]     count_q;
   logic            emerg_vld_q;
   logic [1:0]      emerg_dir_q;

   logic            en_q, dropped_q;
   logic [1:0]      d_q;

   logic            full_w, empty_w;
   logic            pending, runway_free;
   logic            issue;
   logic            pop_emerg, pop_norm;
   logic            push_norm, drop_norm;
   logic            push_emerg, drop_emerg;
   logic [1:0]      issue_dir;

   assign full_w      = (count_q == CNT_MAX);
   assign empty_w     = (count_q == '0);
   assign pending     = emerg_vld_q | ~empty_w;
   assign runway_free = ~runway_a_busy | ~runway_b_busy;

   // Spacing timer is a down-counter; the decision happens at terminal count.
   always_comb begin
      state_d   = state_q;
      spc_cnt_d = spc_cnt_q;
      issue     = 1'b0;
      case (state_q)
         IDLE: begin
            if (pending && runway_free) begin
               issue   = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            state_d   = HOLD;
            spc_cnt_d = SP_LOAD;
         end
         HOLD: begin
            if (spc_cnt_q == '0) begin
               if (pending && runway_free) begin
                  issue   = 1'b1;
                  state_d = ISSUE;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               spc_cnt_d = spc_cnt_q - CW'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Emergency slot outranks the FIFO head.
   assign pop_emerg = issue & emerg_vld_q;
   assign pop_norm  = issue & ~emerg_vld_q;
   assign issue_dir = emerg_vld_q ? emerg_dir_q : fifo_mem[rd_ptr_q];

   // Full is judged before the edge: a same-cycle pop never makes room.
   assign push_norm = req_valid & ~req_emerg & ~full_w;
   assign drop_norm = req_valid & ~req_emerg & full_w;

   // A slot emptied by this cycle's dispatch may take a new emergency at once.
   assign push_emerg = req_valid & req_emerg & (~emerg_vld_q | pop_emerg);
   assign drop_emerg = req_valid & req_emerg & emerg_vld_q & ~pop_emerg;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         spc_cnt_q   <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         emerg_vld_q <= 1'b0;
         emerg_dir_q <= 2'd0;
         en_q        <= 1'b0;
         d_q         <= 2'd0;
         dropped_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         spc_cnt_q <= spc_cnt_d;
         en_q      <= issue;
         dropped_q <= drop_norm | drop_emerg;

         if (issue) begin
            d_q <= issue_dir;
         end

         if (push_norm) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop_norm) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         if (push_norm && !pop_norm) begin
            count_q <= count_q + (AW+1)'(1);
         end else if (pop_norm && !push_norm) begin
            count_q <= count_q - (AW+1)'(1);
         end

         if (push_emerg) begin
            emerg_vld_q <= 1'b1;
            emerg_dir_q <= req_dir;
         end else if (pop_emerg) begin
            emerg_vld_q <= 1'b0;
         end
      end
   end

   // Storage needs no reset; occupancy is carried entirely by count_q.
   always_ff @(posedge clk) begin
      if (!rst && push_norm) begin
         fifo_mem[wr_ptr_q] <= req_dir;
      end
   end

   assign en            = en_q;
   assign d             = d_q;
   assign dropped       = dropped_q;
   assign count         = count_q;
   assign full          = full_w;
   assign empty         = empty_w;
   assign req_ready     = ~full_w;
   assign emerg_pending = emerg_vld_q;

endmodule

// File: tb/tb_landing_request_queue.sv
// Bench for landing_request_queue: vector table, directed corner sequences and
// random traffic, all checked against a queue-based reference model.
module tb_landing_request_queue;

   localparam int DEPTH   = 4;
   localparam int AW      = 2;
   localparam int SPACING = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0;
   logic [1:0]    req_dir = 2'd0;
   logic          req_emerg = 1'b0;
   logic          req_ready;
   logic          runway_a_busy = 1'b0;
   logic          runway_b_busy = 1'b0;
   logic          en;
   logic [1:0]    d;
   logic [AW:0]   count;
   logic          full;
   logic          empty;
   logic          emerg_pending;
   logic          dropped;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   landing_request_queue #(.DEPTH(DEPTH), .AW(AW), .SPACING(SPACING)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_dir(req_dir), .req_emerg(req_emerg),
      .req_ready(req_ready),
      .runway_a_busy(runway_a_busy), .runway_b_busy(runway_b_busy),
      .en(en), .d(d), .count(count), .full(full), .empty(empty),
      .emerg_pending(emerg_pending), .dropped(dropped)
   );

   // Reference model: plain queue + slot + "edges since last dispatch" rule.
   logic [1:0] mq[$];
   bit         ms_v;
   logic [1:0] ms_d;
   bit         m_en, m_drop, m_has;
   logic [1:0] m_d;
   int         m_cyc = 0;
   int         m_last = 0;

   logic [1:0] disp[$];
   int         disp_cyc[$];
   int         peak;
   int         drops;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, m_cyc, act, exp);
      end
   endtask

   task automatic model_edge(input bit r, input bit v, input logic [1:0] dr,
                             input bit em, input bit a, input bit b);
      bit pend, fr, ok, full_pre;
      m_cyc++;
      if (r) begin
         mq.delete();
         ms_v   = 0;
         m_en   = 0;
         m_d    = 2'd0;
         m_drop = 0;
         m_has  = 0;
         return;
      end
      full_pre = (mq.size() == DEPTH);
      pend     = ms_v || (mq.size() > 0);
      fr       = !a || !b;
      ok       = !m_has || (m_cyc - m_last >= SPACING + 1);
      m_en     = 0;
      m_drop   = 0;
      if (pend && fr && ok) begin
         m_en   = 1;
         m_last = m_cyc;
         m_has  = 1;
         if (ms_v) begin
            m_d  = ms_d;
            ms_v = 0;
         end else begin
            m_d = mq.pop_front();
         end
      end
      if (v && !em) begin
         if (full_pre) m_drop = 1;
         else mq.push_back(dr);
      end
      if (v && em) begin
         if (ms_v) m_drop = 1;
         else begin
            ms_v = 1;
            ms_d = dr;
         end
      end
   endtask

   task automatic step(input bit r, input bit v, input logic [1:0] dr,
                       input bit em, input bit a, input bit b);
      rst = r; req_valid = v; req_dir = dr; req_emerg = em;
      runway_a_busy = a; runway_b_busy = b;
      @(posedge clk);
      model_edge(r, v, dr, em, a, b);
      @(negedge clk);
      chk("en",            32'(en),            32'(m_en));
      chk("d",             32'(d),             32'(m_d));
      chk("dropped",       32'(dropped),       32'(m_drop));
      chk("count",         32'(count),         32'(mq.size()));
      chk("full",          32'(full),          32'(mq.size() == DEPTH));
      chk("empty",         32'(empty),         32'(mq.size() == 0));
      chk("req_ready",     32'(req_ready),     32'(mq.size() != DEPTH));
      chk("emerg_pending", 32'(emerg_pending), 32'(ms_v));
      if (en === 1'b1) begin
         disp.push_back(d);
         disp_cyc.push_back(m_cyc);
      end
      if (dropped === 1'b1) drops++;
      if (int'(count) > peak) peak = int'(count);
   endtask

   task automatic idle(input int n, input bit a, input bit b);
      for (int i = 0; i < n; i++) step(0, 0, 2'd0, 0, a, b);
   endtask

   task automatic clear_log();
      disp.delete();
      disp_cyc.delete();
      peak  = 0;
      drops = 0;
   endtask

   typedef struct {
      bit         r, v;
      logic [1:0] dir;
      bit         em, busy;
      bit         x_en;
      logic [1:0] x_d;
      int         x_cnt;
      bit         x_drop, x_em;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input bit r, input bit v, input logic [1:0] dir, input bit em,
                      input bit busy, input bit x_en, input logic [1:0] x_d,
                      input int x_cnt, input bit x_drop, input bit x_em);
      vec_t t;
      t.r = r; t.v = v; t.dir = dir; t.em = em; t.busy = busy;
      t.x_en = x_en; t.x_d = x_d; t.x_cnt = x_cnt; t.x_drop = x_drop; t.x_em = x_em;
      tbl.push_back(t);
   endtask

   initial begin
      // r v dir em busy | en d cnt drop em
      add(1,0,0,0,0, 0,0,0,0,0);   // reset
      add(0,1,2,0,0, 0,0,1,0,0);   // push 2
      add(0,0,0,0,0, 1,2,0,0,0);   // dispatch 2
      add(0,0,0,0,0, 0,2,0,0,0);
      add(0,0,0,0,0, 0,2,0,0,0);
      add(0,1,1,0,1, 0,2,1,0,0);   // queue 1,1,1 with runways busy
      add(0,1,1,0,1, 0,2,2,0,0);
      add(0,1,1,0,1, 0,2,3,0,0);
      add(0,0,0,0,0, 1,1,2,0,0);   // release: dispatch 1
      add(0,1,3,1,0, 0,1,2,0,1);   // emergency 3 during hold
      add(0,1,0,1,0, 0,1,2,1,1);   // second emergency dropped
      add(0,0,0,0,0, 0,1,2,0,1);
      add(0,0,0,0,0, 1,3,2,0,0);   // emergency wins
      add(0,0,0,0,0, 0,3,2,0,0);
      add(0,0,0,0,0, 0,3,2,0,0);
      add(0,0,0,0,0, 0,3,2,0,0);
      add(0,0,0,0,0, 1,1,1,0,0);
      add(0,0,0,0,0, 0,1,1,0,0);
      add(0,0,0,0,0, 0,1,1,0,0);
      add(0,0,0,0,0, 0,1,1,0,0);
      add(0,0,0,0,0, 1,1,0,0,0);
      add(0,0,0,0,0, 0,1,0,0,0);
      add(0,0,0,0,0, 0,1,0,0,0);
      add(0,0,0,0,0, 0,1,0,0,0);
      add(0,0,0,0,0, 0,1,0,0,0);   // terminal count, nothing pending
      add(0,1,2,1,1, 0,1,0,0,1);   // emergency 2 while busy
      add(0,1,1,1,0, 1,2,0,0,1);   // pop 2 and store 1 in same edge
      add(0,0,0,0,0, 0,2,0,0,1);
      add(0,0,0,0,0, 0,2,0,0,1);
      add(0,0,0,0,0, 0,2,0,0,1);
      add(0,0,0,0,0, 1,1,0,0,0);
      add(0,0,0,0,0, 0,1,0,0,0);

      @(negedge clk);
      clear_log();
      foreach (tbl[i]) begin
         step(tbl[i].r, tbl[i].v, tbl[i].dir, tbl[i].em, tbl[i].busy, tbl[i].busy);
         chk("tbl_en",      32'(en),            32'(tbl[i].x_en));
         chk("tbl_d",       32'(d),             32'(tbl[i].x_d));
         chk("tbl_count",   32'(count),         32'(tbl[i].x_cnt));
         chk("tbl_dropped", 32'(dropped),       32'(tbl[i].x_drop));
         chk("tbl_emerg",   32'(emerg_pending), 32'(tbl[i].x_em));
      end

      // Back-to-back pushes of 0..3 with runways free.
      step(1, 0, 2'd0, 0, 0, 0);
      clear_log();
      for (int i = 0; i < 4; i++) step(0, 1, 2'(i), 0, 0, 0);
      idle(16, 0, 0);
      chk("b2b_ndisp", 32'(disp.size()), 32'd4);
      if (disp.size() == 4) begin
         for (int i = 0; i < 4; i++) chk("b2b_order", 32'(disp[i]), 32'(i));
         for (int i = 1; i < 4; i++) chk("b2b_gap", 32'(disp_cyc[i] - disp_cyc[i-1]), 32'(SPACING + 1));
      end
      chk("b2b_peak", 32'(peak), 32'd3);
      chk("b2b_drops", 32'(drops), 32'd0);

      // Fill while both runways busy, overflow once, then release runway B.
      step(1, 0, 2'd0, 0, 1, 1);
      clear_log();
      for (int i = 0; i < 5; i++) step(0, 1, 2'(i % 4), 0, 1, 1);
      idle(3, 1, 1);
      chk("full_count", 32'(count), 32'(DEPTH));
      chk("full_flag", 32'(full), 32'd1);
      chk("full_ready", 32'(req_ready), 32'd0);
      chk("full_drops", 32'(drops), 32'd1);
      chk("full_noen", 32'(disp.size()), 32'd0);
      idle(20, 1, 0);
      chk("drain_ndisp", 32'(disp.size()), 32'd4);
      if (disp.size() == 4)
         for (int i = 0; i < 4; i++) chk("drain_order", 32'(disp[i]), 32'(i));

      // Reset during HOLD with two entries still queued.
      step(1, 0, 2'd0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 1, 2'(i + 1), 0, 1, 1);
      idle(2, 0, 0);
      chk("hold_count", 32'(count), 32'd2);
      step(1, 0, 2'd0, 0, 0, 0);
      clear_log();
      idle(10, 0, 0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_noen", 32'(disp.size()), 32'd0);

      // Simultaneous push and pop at count 2.
      step(1, 0, 2'd0, 0, 0, 0);
      step(0, 1, 2'd1, 0, 1, 1);
      step(0, 1, 2'd2, 0, 1, 1);
      clear_log();
      step(0, 1, 2'd3, 0, 0, 0);
      chk("pp_en", 32'(en), 32'd1);
      chk("pp_d", 32'(d), 32'd1);
      chk("pp_count", 32'(count), 32'd2);
      idle(12, 0, 0);
      chk("pp_ndisp", 32'(disp.size()), 32'd3);
      if (disp.size() == 3) begin
         chk("pp_order1", 32'(disp[1]), 32'd2);
         chk("pp_order2", 32'(disp[2]), 32'd3);
      end

      // Random traffic against the model.
      step(1, 0, 2'd0, 0, 0, 0);
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 199) == 0,
              $urandom_range(0, 1) == 1,
              2'($urandom_range(0, 3)),
              $urandom_range(0, 5) == 0,
              $urandom_range(0, 9) < 4,
              $urandom_range(0, 9) < 4);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
